// File: rtl/gray_fifo_ptr.sv
// gray_fifo_ptr: one side of a dual-clock FIFO. It owns the binary pointer
// and its registered Gray image, and it decodes the peer's synchronised Gray
// pointer. From these it produces the registered full/empty flag, the almost
// flag and the fill level.
module gray_fifo_ptr #(
    parameter int ADDR_WIDTH    = 4,
    parameter bit WRITE_SIDE    = 1'b1,
    parameter int ALMOST_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   remote_gray,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   ptr_bin,
    output logic [ADDR_WIDTH:0]   ptr_gray,
    output logic                  flag,
    output logic                  almost,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int N     = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // When the FIFO is full, the write Gray pointer equals the read Gray
    // pointer with its two MSBs inverted.
    localparam logic [N-1:0] FULL_MASK = N'(3) << (N - 2);
    localparam logic [N-1:0] AF_LEVEL  = N'(DEPTH - ALMOST_THRESH);
    localparam logic [N-1:0] AE_LEVEL  = N'(ALMOST_THRESH);

    // Reset values. The read side starts empty. The write side starts
    // not-full.
    localparam logic FLAG_RST   = ~WRITE_SIDE;
    localparam logic ALMOST_RST = WRITE_SIDE ? ((DEPTH - ALMOST_THRESH) <= 0) : 1'b1;

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit i is the XOR of Gray bits i..N-1.
    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [N-1:0] ptr_bin_q,  ptr_bin_d;
    logic [N-1:0] ptr_gray_q, ptr_gray_d;
    logic [N-1:0] level_q,    level_d;
    logic         flag_q,     flag_d;
    logic         almost_q,   almost_d;

    logic         acc;
    logic [N-1:0] rbin;

    // Next pointer, Gray encode, peer decode and flag/level computation.
    always_comb begin
        acc        = inc & ~flag_q;
        rbin       = gray2bin(remote_gray);
        ptr_bin_d  = ptr_bin_q + N'(acc);
        ptr_gray_d = bin2gray(ptr_bin_d);
        if (WRITE_SIDE) begin
            flag_d   = (ptr_gray_d == (remote_gray ^ FULL_MASK));
            level_d  = ptr_bin_d - rbin;
            almost_d = (level_d >= AF_LEVEL);
        end else begin
            flag_d   = (ptr_gray_d == remote_gray);
            level_d  = rbin - ptr_bin_d;
            almost_d = (level_d <= AE_LEVEL);
        end
    end

    // Pointer and flag registers. Reset has priority over an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            level_q    <= '0;
            flag_q     <= FLAG_RST;
            almost_q   <= ALMOST_RST;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            level_q    <= level_d;
            flag_q     <= flag_d;
            almost_q   <= almost_d;
        end
    end

    assign addr     = ptr_bin_q[ADDR_WIDTH-1:0];
    assign ptr_bin  = ptr_bin_q;
    assign ptr_gray = ptr_gray_q;
    assign flag     = flag_q;
    assign almost   = almost_q;
    assign level    = level_q;

endmodule
